hls_phi_add_core: RTL and testbench



---
 rtl/hls_phi_add_core.sv | 70 +++++++
 tb/tb_hls_phi_add_core.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hls_phi_add_core.sv
// Datapath primitives for HLS-generated FSM controllers: wrapping adder, SSA phi
// selector keyed on predecessor block ID, and optional capture registers.

// Branch stub: branch control lives in the owning FSM, so this is empty.
module br_dummy;
endmodule

module hls_phi_add_core #(
  parameter int WIDTH     = 32,
  parameter int NB_PAIR   = 2,
  parameter int SEL_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             add_in0,
  input  logic [WIDTH-1:0]             add_in1,
  output logic [WIDTH-1:0]             add_out,
  input  logic [NB_PAIR*WIDTH-1:0]     phi_in,
  input  logic [NB_PAIR*SEL_WIDTH-1:0] phi_s,
  input  logic [SEL_WIDTH-1:0]         phi_last_block,
  output logic [WIDTH-1:0]             phi_out,
  output logic                         phi_hit,
  input  logic                         en,
  output logic [WIDTH-1:0]             add_q,
  output logic [WIDTH-1:0]             phi_q
);

  br_dummy u_br_dummy ();

  // Same-width sum: the carry out falls off, giving mod 2^WIDTH wrap.
  assign add_out = add_in0 + add_in1;

  // Per-pair match vector; each bit depends only on its own ID slice.
  logic [NB_PAIR-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NB_PAIR; i++) begin
      match[i] = (phi_s[i*SEL_WIDTH +: SEL_WIDTH] == phi_last_block);
    end
  end

  // Walk from the highest index down so the lowest matching pair is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // phi_out or phi_hit unassigned would infer a latch.
    phi_out = '0;
    phi_hit = 1'b0;
    for (int i = NB_PAIR - 1; i >= 0; i--) begin
      if (match[i]) begin
        phi_out = phi_in[i*WIDTH +: WIDTH];
        phi_hit = 1'b1;
      end
    end
  end

  // Loop-carried value holders; rst wins over en.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so both registers sample the same
    // pre-edge combinational values regardless of statement order.
    if (rst) begin
      add_q <= '0;
      phi_q <= '0;
    end else if (en) begin
      add_q <= add_out;
      phi_q <= phi_out;
    end
  end

endmodule

// File: tb/tb_hls_phi_add_core.sv
// Directed bench for hls_phi_add_core: a vector table for the combinational paths
// on a 32-bit and a 20-bit instance, plus hand sequences for the registers.

module tb_hls_phi_add_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] add_in0, add_in1, add_out, add_q, phi_q, phi_out, phi_last_block;
  logic [63:0] phi_in, phi_s;
  logic        phi_hit;

  // 20-bit instance shares stimulus, truncated per slice.
  logic [19:0] add_in0_20, add_in1_20, add_out_20, phi_out_20, add_q_20, phi_q_20;
  logic [39:0] phi_in_20;
  logic        phi_hit_20;

  assign add_in0_20 = add_in0[19:0];
  assign add_in1_20 = add_in1[19:0];
  assign phi_in_20  = {phi_in[51:32], phi_in[19:0]};

  always #5 clk = ~clk;

  hls_phi_add_core u_dut (
    .clk(clk), .rst(rst),
    .add_in0(add_in0), .add_in1(add_in1), .add_out(add_out),
    .phi_in(phi_in), .phi_s(phi_s), .phi_last_block(phi_last_block),
    .phi_out(phi_out), .phi_hit(phi_hit),
    .en(en), .add_q(add_q), .phi_q(phi_q)
  );

  hls_phi_add_core #(.WIDTH(20), .NB_PAIR(2), .SEL_WIDTH(32)) u_dut20 (
    .clk(clk), .rst(rst),
    .add_in0(add_in0_20), .add_in1(add_in1_20), .add_out(add_out_20),
    .phi_in(phi_in_20), .phi_s(phi_s), .phi_last_block(phi_last_block),
    .phi_out(phi_out_20), .phi_hit(phi_hit_20),
    .en(en), .add_q(add_q_20), .phi_q(phi_q_20)
  );

  typedef struct {
    string       name;
    logic [31:0] a, b, v1, v0, s1, s0, lb;
    logic [31:0] e_add, e_phi;
    logic        e_hit;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //        name        a             b             v1            v0            s1            s0            lb            add           phi           hit
    vecs[0] = '{"wrap",   32'hFFFFFFFF, 32'd1,        32'd7,        32'd0,        32'd1,        32'd0,        32'd0,        32'd0,        32'd0,        1'b1};
    vecs[1] = '{"sel1",   32'd100,      32'd1,        32'd7,        32'd0,        32'd1,        32'd0,        32'd1,        32'd101,      32'd7,        1'b1};
    vecs[2] = '{"miss",   32'h7FFFFFFF, 32'd1,        32'd7,        32'd0,        32'd1,        32'd0,        32'd2,        32'h80000000, 32'd0,        1'b0};
    vecs[3] = '{"prio",   32'd5,        32'hFFFFFFFB, 32'd9,        32'd3,        32'd5,        32'd5,        32'd5,        32'd0,        32'd3,        1'b1};
    vecs[4] = '{"fulleq", 32'd0,        32'd0,        32'd11,       32'd22,       32'd1,        32'h00010000, 32'd0,        32'd0,        32'd0,        1'b0};
    vecs[5] = '{"hiid",   32'd1234,     32'd4321,     32'h000ABCDE, 32'h00012345, 32'hDEADBEEF, 32'd3,        32'hDEADBEEF, 32'd5555,     32'h000ABCDE, 1'b1};

    rst = 1'b1; en = 1'b0;
    add_in0 = '0; add_in1 = '0; phi_in = '0; phi_s = '0; phi_last_block = '0;
    tick();
    tick();
    check("reset_add_q", add_q, 32'd0);
    check("reset_phi_q", phi_q, 32'd0);
    check("reset_add_q20", {12'd0, add_q_20}, 32'd0);
    check("reset_phi_q20", {12'd0, phi_q_20}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      add_in0 = vecs[i].a;
      add_in1 = vecs[i].b;
      phi_in  = {vecs[i].v1, vecs[i].v0};
      phi_s   = {vecs[i].s1, vecs[i].s0};
      phi_last_block = vecs[i].lb;
      #2;
      check({vecs[i].name, "_add"}, add_out, vecs[i].e_add);
      check({vecs[i].name, "_phi"}, phi_out, vecs[i].e_phi);
      check({vecs[i].name, "_hit"}, {31'd0, phi_hit}, {31'd0, vecs[i].e_hit});
      check({vecs[i].name, "_add20"}, {12'd0, add_out_20}, {12'd0, vecs[i].e_add[19:0]});
      check({vecs[i].name, "_phi20"}, {12'd0, phi_out_20}, {12'd0, vecs[i].e_phi[19:0]});
      check({vecs[i].name, "_hit20"}, {31'd0, phi_hit_20}, {31'd0, vecs[i].e_hit});
    end

    // Counter loop: phi picks 0 on entry (block 0), then add_q (block 1); sum feeds back.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b1;
    add_in1 = 32'd1;
    phi_s = {32'd1, 32'd0};
    for (int k = 1; k <= 5; k++) begin
      phi_last_block = (k == 1) ? 32'd0 : 32'd1;
      phi_in = {add_q, 32'd0};
      #1;
      add_in0 = phi_out;
      tick();
      check($sformatf("count_add_q_%0d", k), add_q, k);
      check($sformatf("count_phi_q_%0d", k), phi_q, k - 1);
    end

    en = 1'b0;
    add_in0 = 32'd77;
    phi_last_block = 32'd0;
    tick();
    tick();
    check("hold_add_q", add_q, 32'd5);
    check("hold_phi_q", phi_q, 32'd4);

    // Reset beats enable; combinational outputs keep working under reset.
    en = 1'b1;
    add_in0 = 32'd10;
    add_in1 = 32'd20;
    phi_in = {32'd7, 32'd42};
    phi_s = {32'd1, 32'd0};
    phi_last_block = 32'd0;
    rst = 1'b1;
    tick();
    check("rstprio_add_q", add_q, 32'd0);
    check("rstprio_phi_q", phi_q, 32'd0);
    check("rst_comb_add", add_out, 32'd30);
    check("rst_comb_phi", phi_out, 32'd42);
    rst = 1'b0;
    tick();
    check("resume_add_q", add_q, 32'd30);
    check("resume_phi_q", phi_q, 32'd42);
    check("resume_add_q20", {12'd0, add_q_20}, 32'd30);
    check("resume_phi_q20", {12'd0, phi_q_20}, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
